exposure_ctrl: RTL and testbench

Exposure/readout control FSM that sits directly upstream of `Timer_counter`. It holds the programmable exposure time and drives `Initial` and `Start` into the timer. It consumes the timer's `Ovf5` expiry pulse. It sequences the pixel-array control lines (`Erase`, `Expose`, `NRE_1`, `NRE_2`, `ADC`) through one exposure plus a two-row readout per `Init` request.

---
 rtl/exposure_ctrl.sv | 145 ++++++++++++++
 tb/tb_exposure_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exposure_ctrl.sv
// Exposure/readout sequencer feeding Timer_counter: one exposure plus a two-row readout per Init.
// Every output is registered and decoded from the next state, the next step count and the next entry flag.
module exposure_ctrl #(
   parameter int EXP_W   = 5,
   parameter int EXP_MIN = 2,
   parameter int EXP_MAX = 30,
   parameter int EXP_RST = 15
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Init,
   input  logic             Exp_increase,
   input  logic             Exp_decrease,
   input  logic             Ovf5,
   output logic [EXP_W-1:0] Initial,
   output logic             Start,
   output logic             Erase,
   output logic             Expose,
   output logic             NRE_1,
   output logic             NRE_2,
   output logic             ADC
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXPOSE,
      ST_READOUT
   } state_t;

   localparam logic [EXP_W-1:0] EXP_MIN_V = EXP_W'(EXP_MIN);
   localparam logic [EXP_W-1:0] EXP_MAX_V = EXP_W'(EXP_MAX);
   localparam logic [EXP_W-1:0] EXP_RST_V = EXP_W'(EXP_RST);
   localparam logic [EXP_W-1:0] EXP_ONE   = EXP_W'(1);

   state_t           state_q, state_d;
   logic [2:0]       s_q, s_d;
   logic             first_q, first_d;
   logic [EXP_W-1:0] exp_q, exp_d;
   logic             start_q, start_d;
   logic             erase_q, erase_d;
   logic             expose_q, expose_d;
   logic             nre1_q, nre1_d;
   logic             nre2_q, nre2_d;
   logic             adc_q, adc_d;

   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      first_d  = 1'b0;
      exp_d    = exp_q;
      start_d  = 1'b0;
      erase_d  = 1'b0;
      expose_d = 1'b0;
      nre1_d   = 1'b1;
      nre2_d   = 1'b1;
      adc_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            s_d = 3'd0;
            if (Init) begin
               state_d = ST_EXPOSE;
               first_d = 1'b1;
            end else if (Exp_increase && !Exp_decrease && (exp_q < EXP_MAX_V)) begin
               exp_d = exp_q + EXP_ONE;
            end else if (Exp_decrease && !Exp_increase && (exp_q > EXP_MIN_V)) begin
               exp_d = exp_q - EXP_ONE;
            end
         end
         ST_EXPOSE: begin
            // The timer is still loading in the Start cycle, so an Ovf5 seen there is stale.
            if (Ovf5 && !first_q) begin
               state_d = ST_READOUT;
               s_d     = 3'd0;
            end
         end
         ST_READOUT: begin
            if (s_q == 3'd7) begin
               state_d = ST_IDLE;
               s_d     = 3'd0;
            end else begin
               s_d = s_q + 3'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            s_d     = 3'd0;
         end
      endcase

      case (state_d)
         ST_IDLE: begin
            erase_d = 1'b1;
         end
         ST_EXPOSE: begin
            expose_d = 1'b1;
            start_d  = first_d;
         end
         ST_READOUT: begin
            // Row 1 at steps 0..2, gap at 3, row 2 at 4..6, gap at 7; ADC mid-row.
            nre1_d = !(s_d <= 3'd2);
            nre2_d = !((s_d >= 3'd4) && (s_d <= 3'd6));
            adc_d  = (s_d == 3'd1) || (s_d == 3'd5);
         end
         default: begin
            erase_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q  <= ST_IDLE;
         s_q      <= 3'd0;
         first_q  <= 1'b0;
         exp_q    <= EXP_RST_V;
         start_q  <= 1'b0;
         erase_q  <= 1'b1;
         expose_q <= 1'b0;
         nre1_q   <= 1'b1;
         nre2_q   <= 1'b1;
         adc_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         s_q      <= s_d;
         first_q  <= first_d;
         exp_q    <= exp_d;
         start_q  <= start_d;
         erase_q  <= erase_d;
         expose_q <= expose_d;
         nre1_q   <= nre1_d;
         nre2_q   <= nre2_d;
         adc_q    <= adc_d;
      end
   end

   assign Initial = exp_q;
   assign Start   = start_q;
   assign Erase   = erase_q;
   assign Expose  = expose_q;
   assign NRE_1   = nre1_q;
   assign NRE_2   = nre2_q;
   assign ADC     = adc_q;

endmodule

// File: tb/tb_exposure_ctrl.sv
// Bench for exposure_ctrl: directed vector table, multi-cycle sequences and random stimulus
// checked against a cycle-level behavioural model.
module tb_exposure_ctrl;

   logic       clk;
   logic       rst_n;
   logic       init;
   logic       inc;
   logic       dec;
   logic       ovf;
   logic [4:0] initial_o;
   logic       start_o;
   logic       erase_o;
   logic       expose_o;
   logic       nre1_o;
   logic       nre2_o;
   logic       adc_o;

   int checks   = 0;
   int failures = 0;

   exposure_ctrl #(
      .EXP_W  (5),
      .EXP_MIN(2),
      .EXP_MAX(30),
      .EXP_RST(15)
   ) dut (
      .Clk         (clk),
      .Reset       (rst_n),
      .Init        (init),
      .Exp_increase(inc),
      .Exp_decrease(dec),
      .Ovf5        (ovf),
      .Initial     (initial_o),
      .Start       (start_o),
      .Erase       (erase_o),
      .Expose      (expose_o),
      .NRE_1       (nre1_o),
      .NRE_2       (nre2_o),
      .ADC         (adc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output code order: {Start, Erase, Expose, NRE_1, NRE_2, ADC}
   localparam logic [5:0] O_IDLE  = 6'b010110;
   localparam logic [5:0] O_START = 6'b101110;
   localparam logic [5:0] O_EXP   = 6'b001110;
   localparam logic [5:0] O_R1    = 6'b000010;
   localparam logic [5:0] O_R1A   = 6'b000011;
   localparam logic [5:0] O_GAP   = 6'b000110;
   localparam logic [5:0] O_R2    = 6'b000100;
   localparam logic [5:0] O_R2A   = 6'b000101;

   // Behavioural model: mode 0 idle, 1 exposing, 2 reading out.
   int m_mode;
   int m_age;
   int m_idx;
   int m_exp;
   bit ro_n1  [8] = '{0, 0, 0, 1, 1, 1, 1, 1};
   bit ro_n2  [8] = '{1, 1, 1, 1, 0, 0, 0, 1};
   bit ro_adc [8] = '{0, 1, 0, 0, 0, 1, 0, 0};

   task automatic model_tick(input logic r, input logic i, input logic u, input logic d, input logic o);
      if (!r) begin
         m_mode = 0; m_age = 0; m_idx = 0; m_exp = 15;
      end else if (m_mode == 0) begin
         if (i) begin
            m_mode = 1; m_age = 0;
         end else if (u && !d && m_exp < 30) begin
            m_exp = m_exp + 1;
         end else if (d && !u && m_exp > 2) begin
            m_exp = m_exp - 1;
         end
      end else if (m_mode == 1) begin
         if (o && m_age > 0) begin
            m_mode = 2; m_idx = 0;
         end else begin
            m_age = m_age + 1;
         end
      end else begin
         if (m_idx == 7) m_mode = 0;
         else m_idx = m_idx + 1;
      end
   endtask

   function automatic logic [10:0] model_vec();
      logic s, e, x, n1, n2, a;
      s  = (m_mode == 1) && (m_age == 0);
      e  = (m_mode == 0);
      x  = (m_mode == 1);
      n1 = (m_mode == 2) ? ro_n1[m_idx]  : 1'b1;
      n2 = (m_mode == 2) ? ro_n2[m_idx]  : 1'b1;
      a  = (m_mode == 2) ? ro_adc[m_idx] : 1'b0;
      return {5'(m_exp), s, e, x, n1, n2, a};
   endfunction

   function automatic logic [10:0] dut_vec();
      return {initial_o, start_o, erase_o, expose_o, nre1_o, nre2_o, adc_o};
   endfunction

   task automatic chk(input string name, input logic [10:0] got, input logic [10:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%b expected=%b", name, got, want);
      end
   endtask

   task automatic chk_int(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, got, want);
      end
   endtask

   task automatic step(input logic r, input logic i, input logic u, input logic d, input logic o);
      @(negedge clk);
      rst_n = r; init = i; inc = u; dec = d; ovf = o;
      @(posedge clk);
      model_tick(r, i, u, d, o);
      #1;
      chk("model", dut_vec(), model_vec());
      $display("t=%0t rst=%b init=%b inc=%b dec=%b ovf=%b -> Initial=%0d St=%b Er=%b Ex=%b N1=%b N2=%b ADC=%b",
               $time, r, i, u, d, o, initial_o, start_o, erase_o, expose_o, nre1_o, nre2_o, adc_o);
   endtask

   // Row-enable exclusivity, checked every cycle.
   always @(negedge clk) begin
      checks++;
      if (nre1_o === 1'b0 && nre2_o === 1'b0) begin
         failures++;
         $display("FAIL nre_excl got=NRE_1=0,NRE_2=0 expected=not both low");
      end
   end

   typedef struct {
      logic       r, i, u, d, o;
      logic [4:0] e_init;
      logic [5:0] e_out;
   } vec_t;

   vec_t tbl [19];

   initial begin
      int k0, cnt, ovf_step, idle_step;
      int n_start, n_adc, n1, n2, n_exp, n_idle, ns, guard;
      int st [4];
      logic drive_ovf;

      rst_n = 1'b0; init = 1'b0; inc = 1'b0; dec = 1'b0; ovf = 1'b0;

      tbl[0]  = '{0, 0, 0, 0, 0, 5'd15, O_IDLE};
      tbl[1]  = '{0, 1, 1, 0, 1, 5'd15, O_IDLE};
      tbl[2]  = '{0, 0, 0, 0, 0, 5'd15, O_IDLE};
      tbl[3]  = '{1, 0, 1, 0, 0, 5'd16, O_IDLE};
      tbl[4]  = '{1, 0, 1, 0, 1, 5'd17, O_IDLE};
      tbl[5]  = '{1, 0, 1, 1, 0, 5'd17, O_IDLE};
      tbl[6]  = '{1, 0, 0, 1, 0, 5'd16, O_IDLE};
      tbl[7]  = '{1, 1, 1, 0, 0, 5'd16, O_START};
      tbl[8]  = '{1, 0, 0, 0, 1, 5'd16, O_EXP};
      tbl[9]  = '{1, 1, 1, 0, 0, 5'd16, O_EXP};
      tbl[10] = '{1, 0, 0, 1, 1, 5'd16, O_R1};
      tbl[11] = '{1, 0, 0, 0, 0, 5'd16, O_R1A};
      tbl[12] = '{1, 1, 0, 0, 1, 5'd16, O_R1};
      tbl[13] = '{1, 0, 1, 0, 0, 5'd16, O_GAP};
      tbl[14] = '{1, 0, 0, 0, 1, 5'd16, O_R2};
      tbl[15] = '{1, 0, 0, 0, 0, 5'd16, O_R2A};
      tbl[16] = '{1, 0, 0, 0, 0, 5'd16, O_R2};
      tbl[17] = '{1, 0, 0, 0, 0, 5'd16, O_GAP};
      tbl[18] = '{1, 0, 0, 0, 0, 5'd16, O_IDLE};

      for (int k = 0; k < 19; k++) begin
         step(tbl[k].r, tbl[k].i, tbl[k].u, tbl[k].d, tbl[k].o);
         chk($sformatf("vec%0d", k), dut_vec(), {tbl[k].e_init, tbl[k].e_out});
      end

      // Exposure limits
      for (int k = 0; k < 20; k++) step(1, 0, 1, 0, 0);
      chk_int("climb_max", initial_o, 30);
      for (int k = 0; k < 40; k++) step(1, 0, 0, 1, 0);
      chk_int("fall_min", initial_o, 2);
      for (int k = 0; k < 5; k++) step(1, 0, 1, 1, 0);
      chk_int("both_hold", initial_o, 2);
      for (int k = 0; k < 8; k++) step(1, 0, 1, 0, 0);
      chk_int("set_ten", initial_o, 10);

      // Full cycle with a timer that fires 10 cycles after Start
      k0 = -1; cnt = 0; ovf_step = -1; idle_step = -1;
      n_start = 0; n_adc = 0; n1 = 0; n2 = 0; n_exp = 0;
      for (int k = 0; k < 40; k++) begin
         drive_ovf = 1'b0;
         if (k0 >= 0 && ovf_step < 0) begin
            cnt++;
            if (cnt == 10) begin
               drive_ovf = 1'b1;
               ovf_step  = k;
            end
         end
         step(1, k == 0, 0, 0, drive_ovf);
         if (start_o) begin
            n_start++;
            if (k0 < 0) begin k0 = k; cnt = 0; end
         end
         if (adc_o)    n_adc++;
         if (!nre1_o)  n1++;
         if (!nre2_o)  n2++;
         if (expose_o) n_exp++;
         if (ovf_step >= 0 && idle_step < 0 && erase_o) idle_step = k;
      end
      chk_int("cyc_start", n_start, 1);
      chk_int("cyc_adc", n_adc, 2);
      chk_int("cyc_nre1", n1, 3);
      chk_int("cyc_nre2", n2, 3);
      chk_int("cyc_expose", n_exp, 10);
      chk_int("cyc_ro_len", idle_step - ovf_step, 8);
      chk_int("cyc_initial", initial_o, 10);

      // Reset while row 2 is being read
      step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1);
      guard = 0;
      while (nre2_o !== 1'b0 && guard < 12) begin
         step(1, 0, 0, 0, 0);
         guard++;
      end
      chk_int("mid_reach_s4", guard, 4);
      step(0, 0, 0, 0, 0);
      chk("rst_mid", dut_vec(), {5'd15, O_IDLE});
      step(1, 0, 0, 0, 0);
      chk("rst_mid_after", dut_vec(), {5'd15, O_IDLE});

      // Init and Ovf5 held: back-to-back exposures with one idle cycle between
      for (int j = 0; j < 4; j++) st[j] = -1;
      ns = 0; n_idle = 0;
      for (int k = 0; k < 40; k++) begin
         step(1, 1, 0, 0, 1);
         if (start_o && ns < 4) begin st[ns] = k; ns++; end
         if (erase_o && ns >= 1 && ns < 4) n_idle++;
      end
      chk_int("held_period1", st[1] - st[0], 11);
      chk_int("held_period2", st[2] - st[1], 11);
      chk_int("held_period3", st[3] - st[2], 11);
      chk_int("held_idle", n_idle, 3);

      // Random stimulus against the model
      for (int k = 0; k < 400; k++) begin
         step($urandom_range(0, 99) >= 3, $urandom_range(0, 4) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 2) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
